// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline register bank: carries EX results through MEM into WB,
// selects write-back data, inserts WB bubbles on data-memory stalls, counts retirements.
module ex_mem_wb_pipe #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_regw,
  input  logic             ex_memtoreg,
  input  logic             ex_memr,
  input  logic             ex_memw,
  input  logic [XLEN-1:0]  ex_alu_res,
  input  logic [XLEN-1:0]  ex_store_data,
  input  logic             mem_stall,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             EM_valid,
  output logic [4:0]       EM_rd,
  output logic             EM_regw,
  output logic             EM_memr,
  output logic             EM_memw,
  output logic [XLEN-1:0]  EM_alu_res,
  output logic [XLEN-1:0]  EM_store_data,
  output logic             MW_valid,
  output logic [4:0]       MW_rd,
  output logic             MW_regw,
  output logic [XLEN-1:0]  MW_wb_data,
  output logic [CNT_W-1:0] retire_cnt
);

  logic memtoreg_em;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // pre-edge values; the MEM/WB capture below relies on reading the old EM_* values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      EM_valid      <= 1'b0;
      EM_rd         <= '0;
      EM_regw       <= 1'b0;
      EM_memr       <= 1'b0;
      EM_memw       <= 1'b0;
      EM_alu_res    <= '0;
      EM_store_data <= '0;
      memtoreg_em   <= 1'b0;
      MW_valid      <= 1'b0;
      MW_rd         <= '0;
      MW_regw       <= 1'b0;
      MW_wb_data    <= '0;
      retire_cnt    <= '0;
    end else begin
      if (MW_valid) begin
        retire_cnt <= retire_cnt + CNT_W'(1);
      end

      if (mem_stall) begin
        // EX/MEM holds so the memory request persists; WB sees a bubble.
        MW_valid <= 1'b0;
        MW_rd    <= '0;
        MW_regw  <= 1'b0;
      end else begin
        EM_valid      <= ex_valid;
        EM_rd         <= ex_valid ? ex_rd : 5'd0;
        EM_regw       <= ex_valid & ex_regw & (ex_rd != 5'd0);
        EM_memr       <= ex_valid & ex_memr;
        EM_memw       <= ex_valid & ex_memw;
        EM_alu_res    <= ex_alu_res;
        EM_store_data <= ex_store_data;
        memtoreg_em   <= ex_memtoreg;

        MW_valid   <= EM_valid;
        MW_rd      <= EM_rd;
        MW_regw    <= EM_regw;
        MW_wb_data <= memtoreg_em ? dmem_rdata : EM_alu_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Self-checking bench for ex_mem_wb_pipe: directed scenarios plus randomized traffic
// compared against an instruction-level reference model.
module tb_ex_mem_wb_pipe;
  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             ex_valid, ex_regw, ex_memtoreg, ex_memr, ex_memw, mem_stall;
  logic [4:0]       ex_rd;
  logic [XLEN-1:0]  ex_alu_res, ex_store_data, dmem_rdata;
  logic             EM_valid, EM_regw, EM_memr, EM_memw, MW_valid, MW_regw;
  logic [4:0]       EM_rd, MW_rd;
  logic [XLEN-1:0]  EM_alu_res, EM_store_data, MW_wb_data;
  logic [CNT_W-1:0] retire_cnt;

  int checks   = 0;
  int failures = 0;

  ex_mem_wb_pipe #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regw(ex_regw), .ex_memtoreg(ex_memtoreg),
    .ex_memr(ex_memr), .ex_memw(ex_memw), .ex_alu_res(ex_alu_res),
    .ex_store_data(ex_store_data), .mem_stall(mem_stall), .dmem_rdata(dmem_rdata),
    .EM_valid(EM_valid), .EM_rd(EM_rd), .EM_regw(EM_regw), .EM_memr(EM_memr),
    .EM_memw(EM_memw), .EM_alu_res(EM_alu_res), .EM_store_data(EM_store_data),
    .MW_valid(MW_valid), .MW_rd(MW_rd), .MW_regw(MW_regw), .MW_wb_data(MW_wb_data),
    .retire_cnt(retire_cnt)
  );

  always #5 clk_i = ~clk_i;

  logic [115:0] obs_vec;
  assign obs_vec = {EM_valid, EM_rd, EM_regw, EM_memr, EM_memw, EM_alu_res, EM_store_data,
                    MW_valid, MW_rd, MW_regw, MW_wb_data, retire_cnt};

  // Reference model: the instruction sitting in MEM, what WB shows, and a total retire count.
  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        regw, memr, memw, m2r;
    logic [31:0] alu, sd;
  } instr_t;

  instr_t      m_mem;
  logic        m_wb_valid, m_wb_regw;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;
  int unsigned m_retired;

  function automatic logic [115:0] exp_vec();
    return {m_mem.valid, m_mem.rd, m_mem.regw, m_mem.memr, m_mem.memw, m_mem.alu, m_mem.sd,
            m_wb_valid, m_wb_rd, m_wb_regw, m_wb_data, CNT_W'(m_retired % (1 << CNT_W))};
  endfunction

  task automatic model_step();
    instr_t nxt;
    if (rst_i) begin
      m_mem = '0; m_wb_valid = 0; m_wb_rd = 0; m_wb_regw = 0; m_wb_data = 0; m_retired = 0;
    end else begin
      if (m_wb_valid) m_retired++;
      if (mem_stall) begin
        m_wb_valid = 0; m_wb_rd = 0; m_wb_regw = 0;
      end else begin
        m_wb_valid = m_mem.valid;
        m_wb_rd    = m_mem.rd;
        m_wb_regw  = m_mem.regw;
        m_wb_data  = m_mem.m2r ? dmem_rdata : m_mem.alu;
        nxt.valid = ex_valid;
        nxt.rd    = ex_valid ? ex_rd : 5'd0;
        nxt.regw  = ex_valid && ex_regw && (ex_rd != 0);
        nxt.memr  = ex_valid && ex_memr;
        nxt.memw  = ex_valid && ex_memw;
        nxt.m2r   = ex_memtoreg;
        nxt.alu   = ex_alu_res;
        nxt.sd    = ex_store_data;
        m_mem = nxt;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    model_step();
    #1;
  endtask

  task automatic rand_ex();
    ex_valid      = 1'($urandom);
    ex_rd         = 5'($urandom);
    ex_regw       = 1'($urandom);
    ex_memtoreg   = 1'($urandom);
    ex_memr       = 1'($urandom);
    ex_memw       = 1'($urandom);
    ex_alu_res    = $urandom;
    ex_store_data = $urandom;
    dmem_rdata    = $urandom;
  endtask

  task automatic set_ex(input logic v, input logic [4:0] rd, input logic regw, input logic m2r,
                        input logic mr, input logic mw, input logic [31:0] alu);
    ex_valid = v; ex_rd = rd; ex_regw = regw; ex_memtoreg = m2r;
    ex_memr = mr; ex_memw = mw; ex_alu_res = alu; ex_store_data = $urandom;
  endtask

  task automatic test_reset();
    rand_ex();
    mem_stall = 1'($urandom);
    rst_i = 1;
    tick();
    rand_ex();
    tick();
    checks++;
    if (obs_vec !== 116'd0) begin
      failures++;
      $display("FAIL reset_outputs got %h exp 0", obs_vec);
    end
    rst_i = 0;
    mem_stall = 0;
  endtask

  task automatic test_alu_op();
    set_ex(1, 5'd5, 1, 0, 0, 0, 32'h1234);
    tick();
    checks++;
    if ({EM_rd, EM_regw} !== {5'd5, 1'b1}) begin
      failures++;
      $display("FAIL alu_em got rd=%0d regw=%0b exp rd=5 regw=1", EM_rd, EM_regw);
    end
    set_ex(0, 0, 0, 0, 0, 0, 0);
    tick();
    checks++;
    if ({MW_rd, MW_regw, MW_wb_data} !== {5'd5, 1'b1, 32'h1234}) begin
      failures++;
      $display("FAIL alu_mw got rd=%0d regw=%0b data=%h exp rd=5 regw=1 data=1234",
               MW_rd, MW_regw, MW_wb_data);
    end
    tick();
    checks++;
    if (retire_cnt !== 4'd1) begin
      failures++;
      $display("FAIL alu_retire got %0d exp 1", retire_cnt);
    end
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL alu_model got %h exp %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_load_stall();
    set_ex(1, 5'd7, 1, 1, 1, 0, 32'h100);
    tick();
    checks++;
    if (EM_memr !== 1'b1) begin
      failures++;
      $display("FAIL load_memr_0 got %0b exp 1", EM_memr);
    end
    mem_stall = 1;
    for (int i = 0; i < 2; i++) begin
      rand_ex();
      tick();
      checks++;
      if ({EM_memr, EM_rd, MW_valid, MW_regw} !== {1'b1, 5'd7, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL load_stall_%0d got memr=%0b rd=%0d mwv=%0b mwregw=%0b exp 1 7 0 0",
                 i, EM_memr, EM_rd, MW_valid, MW_regw);
      end
    end
    mem_stall = 0;
    set_ex(0, 0, 0, 0, 0, 0, 0);
    dmem_rdata = 32'hDEADBEEF;
    tick();
    checks++;
    if ({MW_valid, MW_rd, MW_regw, MW_wb_data} !== {1'b1, 5'd7, 1'b1, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL load_wb got v=%0b rd=%0d regw=%0b data=%h exp 1 7 1 deadbeef",
               MW_valid, MW_rd, MW_regw, MW_wb_data);
    end
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL load_model got %h exp %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_gating();
    logic [CNT_W-1:0] cnt_before;
    set_ex(1, 5'd0, 1, 0, 0, 0, 32'h55);
    tick();
    checks++;
    if ({EM_valid, EM_regw} !== 2'b10) begin
      failures++;
      $display("FAIL x0_gate got valid=%0b regw=%0b exp 1 0", EM_valid, EM_regw);
    end
    set_ex(0, 5'd3, 1, 0, 1, 1, 32'h66);
    tick();
    checks++;
    if ({EM_valid, EM_regw, EM_rd, EM_memr, EM_memw} !== 9'd0) begin
      failures++;
      $display("FAIL bubble_gate got v=%0b regw=%0b rd=%0d memr=%0b memw=%0b exp all 0",
               EM_valid, EM_regw, EM_rd, EM_memr, EM_memw);
    end
    set_ex(0, 0, 0, 0, 0, 0, 0);
    tick();
    cnt_before = retire_cnt;
    tick();
    checks++;
    if (retire_cnt !== cnt_before) begin
      failures++;
      $display("FAIL bubble_retire got %0d exp %0d", retire_cnt, cnt_before);
    end
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL gating_model got %h exp %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_counter_wrap();
    rst_i = 1;
    tick();
    rst_i = 0;
    for (int i = 0; i < 17; i++) begin
      set_ex(1, 5'($urandom_range(1, 31)), 1, 0, 0, 0, $urandom);
      tick();
    end
    set_ex(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    checks++;
    if (retire_cnt !== 4'd1) begin
      failures++;
      $display("FAIL counter_wrap got %0d exp 1", retire_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] held;
    set_ex(1, 5'd9, 1, 0, 0, 1, $urandom);
    tick();
    held = EM_alu_res;
    mem_stall = 1;
    for (int i = 0; i < 10; i++) begin
      rand_ex();
      tick();
      checks++;
      if ({EM_alu_res, EM_memw, EM_rd} !== {held, 1'b1, 5'd9} || MW_valid !== 1'b0) begin
        failures++;
        $display("FAIL long_stall_%0d got alu=%h memw=%0b rd=%0d mwv=%0b exp %h 1 9 0",
                 i, EM_alu_res, EM_memw, EM_rd, MW_valid, held);
      end
    end
    mem_stall = 0;
    tick();
    checks++;
    if (obs_vec !== exp_vec()) begin
      failures++;
      $display("FAIL long_stall_model got %h exp %h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_stall();
    set_ex(1, 5'd0, 0, 0, 0, 1, 32'h200);
    tick();
    mem_stall = 1;
    rand_ex();
    tick();
    checks++;
    if (EM_memw !== 1'b1) begin
      failures++;
      $display("FAIL store_held got %0b exp 1", EM_memw);
    end
    rst_i = 1;
    tick();
    checks++;
    if ({EM_memw, EM_memr, EM_valid} !== 3'b000 || obs_vec !== 116'd0) begin
      failures++;
      $display("FAIL reset_mid_stall got memw=%0b valid=%0b vec=%h exp all 0",
               EM_memw, EM_valid, obs_vec);
    end
    rst_i = 0;
    mem_stall = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rand_ex();
      mem_stall = ($urandom_range(0, 3) == 0);
      rst_i     = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
        failures++;
        $display("FAIL random_%0d got %h exp %h", i, obs_vec, exp_vec());
      end
    end
    rst_i = 0;
    mem_stall = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst_i = 1;
    mem_stall = 0;
    rand_ex();
    @(negedge clk_i);
    test_reset();
    test_alu_op();
    test_load_stall();
    test_gating();
    test_back_to_back();
    test_counter_wrap();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
